// File: rtl/matmul_drain.sv
// Result drain: captures a left_size x right_size matrix of 32-bit results on in_done and streams
// it row-major over valid/ready. Define MATMUL_DRAIN_INDEX_EN to add out_row/out_col outputs.
module matmul_drain #(
  parameter int unsigned left_size  = 2,
  parameter int unsigned right_size = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [left_size-1:0][right_size-1:0][31:0] in_result,
  input  logic                                      in_done,
  output logic                                      busy,
  output logic                                      overrun,
  output logic [31:0]                               out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_last
`ifdef MATMUL_DRAIN_INDEX_EN
  ,
  output logic [$clog2((left_size > 2) ? left_size : 2)-1:0]   out_row,
  output logic [$clog2((right_size > 2) ? right_size : 2)-1:0] out_col
`endif
);

  localparam int unsigned N  = left_size * right_size;
  localparam int unsigned KW = $clog2((N > 2) ? N : 2);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N*32-1:0] mat_q;
  logic            overrun_q, overrun_d;
  logic            capture;
  logic            last_k;
  logic            fire;

  assign last_k    = (k_q == KW'(N - 1));
  assign out_valid = (state_q == StStream);
  assign busy      = out_valid;
  assign fire      = out_valid & out_ready;
  assign out_last  = out_valid & last_k;
  assign overrun   = overrun_q;
  // Packed row-major layout puts element (i,j) at slot i*right_size+j, so k indexes directly.
  assign out_data  = mat_q[32*k_q +: 32];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    capture   = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_done) begin
          capture = 1'b1;
          k_d     = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (fire && last_k) begin
          // A capture landing on the final handshake refills the buffer with no bubble.
          if (in_done) begin
            capture = 1'b1;
            k_d     = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (fire) k_d = k_q + 1'b1;
          overrun_d = in_done;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      mat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      overrun_q <= overrun_d;
      if (capture) mat_q <= in_result;
    end
  end

`ifdef MATMUL_DRAIN_INDEX_EN
  localparam int unsigned RW = $clog2((left_size > 2) ? left_size : 2);
  localparam int unsigned CW = $clog2((right_size > 2) ? right_size : 2);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Wrapping counters track k / right_size and k % right_size without a divider.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (capture) begin
      row_d = '0;
      col_d = '0;
    end else if (fire && !last_k) begin
      if (col_q == CW'(right_size - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign out_row = row_q;
  assign out_col = col_q;
`endif

endmodule
